// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM arbiter: FSM states, port indices
// and the refresh interval computation.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int NPORT = 3;

  localparam logic [1:0] PORT_DISP = 2'd0;
  localparam logic [1:0] PORT_CPU  = 2'd1;
  localparam logic [1:0] PORT_CMD  = 2'd2;

  // Clock cycles between auto-refreshes; integer MHz keeps the math exact at 54 MHz.
  function automatic int refresh_cycles(input int freq_hz, input int interval_ns);
    return freq_hz / 1_000_000 * interval_ns / 1000;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running auto-refresh interval timer with a pending request flag and a
// sticky overrun flag for intervals that expire before the last one was served.
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int FREQ       = 54_000_000,
  parameter int REFRESH_NS = 15_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic refresh_issued,
  output logic refresh_pending,
  output logic refresh_overrun
);

  localparam int RC = refresh_cycles(FREQ, REFRESH_NS);
  localparam int CW = (RC > 1) ? $clog2(RC) : 1;
  localparam logic [CW-1:0] LAST = CW'(RC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          wrap;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    wrap      = (cnt_q == LAST);
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    pending_d = pending_q;
    if (refresh_issued) pending_d = 1'b0;
    if (wrap)           pending_d = 1'b1;
    // A refresh issued on the wrap cycle served the previous interval in time.
    overrun_d = overrun_q | (wrap & pending_q & ~refresh_issued);
  end

  // NOTE: state flops use non-blocking assignments only; the async reset covers every flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign refresh_pending = pending_q;
  assign refresh_overrun = overrun_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port SDRAM controller arbiter with auto-refresh scheduling.
// Define SDRAM_ARB_STATS_EN to add saturating grant and refresh counters.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int FREQ       = 54_000_000,
  parameter int REFRESH_NS = 15_000,
  parameter int AW         = 22
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [2:0]      p_req,
  input  logic [2:0]      p_we,
  input  logic [3*AW-1:0] p_addr,
  input  logic [47:0]     p_din,
  input  logic [5:0]      p_wdm,
  output logic [2:0]      p_ack,
  output logic [2:0]      p_done,
  output logic [15:0]     rdata,
  output logic            mc_read,
  output logic            mc_write,
  output logic            mc_refresh,
  output logic [AW-1:0]   mc_addr,
  output logic [15:0]     mc_din,
  output logic [1:0]      mc_wdm,
  input  logic            mc_busy,
  input  logic [15:0]     mc_dout,
  output logic            refresh_overrun
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [47:0]     grant_count,
  output logic [15:0]     refresh_count
`endif
);

  arb_state_e    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          is_read_q, is_read_d;
  logic          is_refresh_q, is_refresh_d;
  logic [1:0]    rr_last_q, rr_last_d;
  logic          mc_read_q, mc_read_d;
  logic          mc_write_q, mc_write_d;
  logic          mc_refresh_q, mc_refresh_d;
  logic [AW-1:0] mc_addr_q, mc_addr_d;
  logic [15:0]   mc_din_q, mc_din_d;
  logic [1:0]    mc_wdm_q, mc_wdm_d;
  logic [2:0]    p_ack_q, p_ack_d;
  logic [2:0]    p_done_q, p_done_d;
  logic [15:0]   rdata_q, rdata_d;

  logic          refresh_pending;
  logic          refresh_issued;
  logic          grant_valid;
  logic [1:0]    grant_port;
  int            gi;

  sdram_refresh_timer #(
    .FREQ       (FREQ),
    .REFRESH_NS (REFRESH_NS)
  ) u_refresh_timer (
    .clk             (clk),
    .resetn          (resetn),
    .refresh_issued  (refresh_issued),
    .refresh_pending (refresh_pending),
    .refresh_overrun (refresh_overrun)
  );

  // Display fetch has fixed priority; CPU and command engine share round-robin.
  always_comb begin
    grant_valid = 1'b1;
    grant_port  = PORT_DISP;
    if (p_req[PORT_DISP]) begin
      grant_port = PORT_DISP;
    end else if (p_req[PORT_CPU] && p_req[PORT_CMD]) begin
      grant_port = (rr_last_q == PORT_CPU) ? PORT_CMD : PORT_CPU;
    end else if (p_req[PORT_CPU]) begin
      grant_port = PORT_CPU;
    end else if (p_req[PORT_CMD]) begin
      grant_port = PORT_CMD;
    end else begin
      grant_valid = 1'b0;
    end
  end

  assign gi = int'(grant_port);

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    is_read_d      = is_read_q;
    is_refresh_d   = is_refresh_q;
    rr_last_d      = rr_last_q;
    mc_read_d      = 1'b0;
    mc_write_d     = 1'b0;
    mc_refresh_d   = 1'b0;
    mc_addr_d      = mc_addr_q;
    mc_din_d       = mc_din_q;
    mc_wdm_d       = mc_wdm_q;
    p_ack_d        = 3'b000;
    p_done_d       = 3'b000;
    rdata_d        = rdata_q;
    refresh_issued = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Busy also covers controller init after reset, so nothing issues until it ends.
        if (!mc_busy) begin
          if (refresh_pending) begin
            mc_refresh_d   = 1'b1;
            refresh_issued = 1'b1;
            is_refresh_d   = 1'b1;
            is_read_d      = 1'b0;
            state_d        = ISSUE;
          end else if (grant_valid) begin
            mc_addr_d           = p_addr[gi*AW +: AW];
            mc_din_d            = p_din[gi*16 +: 16];
            mc_wdm_d            = p_wdm[gi*2 +: 2];
            mc_read_d           = ~p_we[grant_port];
            mc_write_d          = p_we[grant_port];
            p_ack_d[grant_port] = 1'b1;
            owner_d             = grant_port;
            is_read_d           = ~p_we[grant_port];
            is_refresh_d        = 1'b0;
            if (grant_port != PORT_DISP) rr_last_d = grant_port;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!mc_busy) begin
          if (!is_refresh_q) p_done_d[owner_q] = 1'b1;
          if (is_read_q)     rdata_d = mc_dout;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= PORT_DISP;
      is_read_q    <= 1'b0;
      is_refresh_q <= 1'b0;
      rr_last_q    <= PORT_CMD;
      mc_read_q    <= 1'b0;
      mc_write_q   <= 1'b0;
      mc_refresh_q <= 1'b0;
      mc_addr_q    <= '0;
      mc_din_q     <= '0;
      mc_wdm_q     <= '0;
      p_ack_q      <= '0;
      p_done_q     <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      is_read_q    <= is_read_d;
      is_refresh_q <= is_refresh_d;
      rr_last_q    <= rr_last_d;
      mc_read_q    <= mc_read_d;
      mc_write_q   <= mc_write_d;
      mc_refresh_q <= mc_refresh_d;
      mc_addr_q    <= mc_addr_d;
      mc_din_q     <= mc_din_d;
      mc_wdm_q     <= mc_wdm_d;
      p_ack_q      <= p_ack_d;
      p_done_q     <= p_done_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mc_read    = mc_read_q;
  assign mc_write   = mc_write_q;
  assign mc_refresh = mc_refresh_q;
  assign mc_addr    = mc_addr_q;
  assign mc_din     = mc_din_q;
  assign mc_wdm     = mc_wdm_q;
  assign p_ack      = p_ack_q;
  assign p_done     = p_done_q;
  assign rdata      = rdata_q;

`ifdef SDRAM_ARB_STATS_EN
  logic [47:0] grant_cnt_q, grant_cnt_d;
  logic [15:0] refresh_cnt_q, refresh_cnt_d;

  always_comb begin
    grant_cnt_d   = grant_cnt_q;
    refresh_cnt_d = refresh_cnt_q;
    for (int i = 0; i < NPORT; i++) begin
      if (p_ack_q[i] && (grant_cnt_q[i*16 +: 16] != 16'hFFFF))
        grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
    end
    if (mc_refresh_q && (refresh_cnt_q != 16'hFFFF))
      refresh_cnt_d = refresh_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_cnt_q   <= '0;
      refresh_cnt_q <= '0;
    end else begin
      grant_cnt_q   <= grant_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
    end
  end

  assign grant_count   = grant_cnt_q;
  assign refresh_count = refresh_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small behavioural SDRAM controller
// model (4-cycle busy per op, holds last read data).
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int AW = 22;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [2:0]      p_req = '0;
  logic [2:0]      p_we = '0;
  logic [3*AW-1:0] p_addr = '0;
  logic [47:0]     p_din = '0;
  logic [5:0]      p_wdm = '0;
  logic [2:0]      p_ack;
  logic [2:0]      p_done;
  logic [15:0]     rdata;
  logic            mc_read;
  logic            mc_write;
  logic            mc_refresh;
  logic [AW-1:0]   mc_addr;
  logic [15:0]     mc_din;
  logic [1:0]      mc_wdm;
  logic            mc_busy;
  logic [15:0]     mc_dout;
  logic            refresh_overrun;

  logic            init_hold = 1'b1;
  logic [15:0]     rd_val = '0;
  int              op_cnt;
  logic            rd_pend;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};

  sdram_arbiter #(
    .FREQ       (54_000_000),
    .REFRESH_NS (15_000),
    .AW         (AW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .p_req           (p_req),
    .p_we            (p_we),
    .p_addr          (p_addr),
    .p_din           (p_din),
    .p_wdm           (p_wdm),
    .p_ack           (p_ack),
    .p_done          (p_done),
    .rdata           (rdata),
    .mc_read         (mc_read),
    .mc_write        (mc_write),
    .mc_refresh      (mc_refresh),
    .mc_addr         (mc_addr),
    .mc_din          (mc_din),
    .mc_wdm          (mc_wdm),
    .mc_busy         (mc_busy),
    .mc_dout         (mc_dout),
    .refresh_overrun (refresh_overrun)
  );

  always #5 clk = ~clk;

  // Controller model: busy for 4 cycles after seeing a strobe, read data appears as busy drops.
  assign mc_busy = init_hold | (op_cnt != 0);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_cnt  <= 0;
      rd_pend <= 1'b0;
      mc_dout <= '0;
    end else if (mc_read || mc_write || mc_refresh) begin
      op_cnt  <= 4;
      rd_pend <= mc_read;
    end else if (op_cnt != 0) begin
      op_cnt <= op_cnt - 1;
      if (op_cnt == 1 && rd_pend) begin
        mc_dout <= rd_val;
        rd_pend <= 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (p_ack[i])  ack_cnt[i]  <= ack_cnt[i] + 1;
      if (p_done[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // which: 0 = any p_ack, 1 = any p_done, 2 = mc_refresh, 3 = any strobe
  task automatic wait_for(input int which, input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = |p_ack;
        1:       ok = |p_done;
        2:       ok = mc_refresh;
        default: ok = mc_read | mc_write | mc_refresh;
      endcase
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_strobes"}, {61'd0, mc_read, mc_write, mc_refresh}, 64'd0);
    check({pfx, "_ack_done"}, {58'd0, p_ack, p_done}, 64'd0);
    check({pfx, "_mc_addr"}, 64'(mc_addr), 64'd0);
    check({pfx, "_mc_din_wdm"}, {46'd0, mc_din, mc_wdm}, 64'd0);
    check({pfx, "_rdata"}, 64'(rdata), 64'd0);
    check({pfx, "_overrun"}, 64'(refresh_overrun), 64'd0);
  endtask

  initial begin
    logic ok;
    int   seen;
    int   t_ack, t_a, t_b, t_c;
    int   a1, d0, d2;
    logic [2:0] exp_port;

    // Reset and controller init: nothing may issue while busy is high.
    p_addr[0*AW +: AW] = 22'h00_0100;
    p_addr[1*AW +: AW] = 22'h00_0200;
    p_addr[2*AW +: AW] = 22'h00_0300;
    p_req = 3'b111;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    resetn = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (mc_read || mc_write || mc_refresh || (|p_ack)) seen++;
    end
    check("init_no_issue", 64'(seen), 64'd0);
    init_hold = 1'b0;
    wait_for(0, 20, ok);
    check("t1_ack_seen", 64'(ok), 64'd1);
    check("t1_first_grant", 64'(p_ack), 64'b001);
    check("t1_read_strobe", {62'd0, mc_read, mc_write}, 64'b10);
    check("t1_addr", 64'(mc_addr), 64'h00_0100);
    p_req = 3'b000;
    wait_for(1, 20, ok);
    check("t1_done", 64'(p_done), 64'b001);

    // Ports 1 and 2 both requesting: alternate starting with port 1.
    p_we = 3'b110;
    p_din[1*16 +: 16] = 16'h1111;
    p_din[2*16 +: 16] = 16'h2222;
    p_req = 3'b110;
    for (int k = 0; k < 4; k++) begin
      exp_port = (k % 2 == 0) ? 3'b010 : 3'b100;
      wait_for(0, 2000, ok);
      check("rr_ack_seen", 64'(ok), 64'd1);
      check($sformatf("rr_grant_%0d", k), 64'(p_ack), 64'(exp_port));
      if (k == 3) p_req = 3'b000;
    end
    wait_for(1, 20, ok);
    check("rr_last_done", 64'(p_done), 64'b100);

    // Port 1 read: one ack, done and data exactly 6 cycles later.
    repeat (3) @(negedge clk);
    a1 = ack_cnt[1];
    rd_val = 16'hBEEF;
    p_we = 3'b000;
    p_addr[1*AW +: AW] = 22'h00_1234;
    p_req = 3'b010;
    wait_for(0, 2000, ok);
    check("rd_ack_seen", 64'(ok), 64'd1);
    check("rd_ack_port", 64'(p_ack), 64'b010);
    check("rd_strobe", {62'd0, mc_read, mc_write}, 64'b10);
    check("rd_addr", 64'(mc_addr), 64'h00_1234);
    t_ack = cyc;
    p_req = 3'b000;
    wait_for(1, 20, ok);
    check("rd_done_seen", 64'(ok), 64'd1);
    check("rd_done_port", 64'(p_done), 64'b010);
    check("rd_data", 64'(rdata), 64'hBEEF);
    check("rd_latency", 64'(cyc - t_ack), 64'd6);
    repeat (5) @(negedge clk);
    check("rd_single_ack", 64'(ack_cnt[1] - a1), 64'd1);

    // Port 0 with port 1 competing: port 1 never wins.
    rd_val = 16'h0F0F;
    a1 = ack_cnt[1];
    d0 = done_cnt[0];
    p_req = 3'b011;
    for (int k = 0; k < 5; k++) begin
      wait_for(0, 2000, ok);
      check("p0_ack_seen", 64'(ok), 64'd1);
      check($sformatf("p0_only_%0d", k), 64'(p_ack), 64'b001);
      if (k == 4) p_req = 3'b000;
    end
    wait_for(1, 20, ok);
    repeat (3) @(negedge clk);
    check("p0_no_p1_ack", 64'(ack_cnt[1] - a1), 64'd0);
    check("p0_done_count", 64'(done_cnt[0] - d0), 64'd5);
    check("p0_rdata", 64'(rdata), 64'h0F0F);

    // Idle ports: steady refresh period.
    wait_for(2, 2000, ok);
    t_a = cyc;
    wait_for(2, 2000, ok);
    t_b = cyc;
    wait_for(2, 2000, ok);
    t_c = cyc;
    check("ref_seen", 64'(ok), 64'd1);
    check("ref_ack_none", 64'(p_ack), 64'd0);
    check("ref_period", 64'(t_c - t_b), 64'd810);
    check("ref_period_prev_le", 64'(t_b - t_a <= 810), 64'd1);
    check("ref_no_overrun", 64'(refresh_overrun), 64'd0);

    // Controller stalled for 2000 cycles: two intervals expire, overrun sticks.
    repeat (10) @(negedge clk);
    init_hold = 1'b1;
    p_req = 3'b001;
    seen = 0;
    repeat (2000) begin
      @(negedge clk);
      if (mc_read || mc_write || mc_refresh || (|p_ack)) seen++;
    end
    check("stall_no_issue", 64'(seen), 64'd0);
    check("overrun_set", 64'(refresh_overrun), 64'd1);
    init_hold = 1'b0;
    wait_for(3, 20, ok);
    check("stall_first_is_refresh", {61'd0, mc_read, mc_write, mc_refresh}, 64'b001);
    check("stall_refresh_no_ack", 64'(p_ack), 64'd0);
    wait_for(0, 20, ok);
    check("stall_then_port0", 64'(p_ack), 64'b001);
    p_req = 3'b000;
    wait_for(1, 20, ok);

    // Port 2 write: single-cycle strobe with its data and mask; rdata untouched.
    p_we = 3'b100;
    p_addr[2*AW +: AW] = 22'h3A_BCDE;
    p_din[2*16 +: 16] = 16'h55AA;
    p_wdm[2*2 +: 2] = 2'b01;
    p_req = 3'b100;
    wait_for(0, 2000, ok);
    check("wr_ack_port", 64'(p_ack), 64'b100);
    check("wr_strobe", {62'd0, mc_read, mc_write}, 64'b01);
    check("wr_din", 64'(mc_din), 64'h55AA);
    check("wr_wdm", 64'(mc_wdm), 64'b01);
    check("wr_addr", 64'(mc_addr), 64'h3A_BCDE);
    p_req = 3'b000;
    @(negedge clk);
    check("wr_strobe_one_cycle", 64'(mc_write), 64'd0);
    wait_for(1, 20, ok);
    check("wr_done_port", 64'(p_done), 64'b100);
    check("wr_rdata_kept", 64'(rdata), 64'h0F0F);

    // Reset during WAIT: everything clears and the aborted op never completes.
    p_din[2*16 +: 16] = 16'h1234;
    p_req = 3'b100;
    wait_for(0, 2000, ok);
    check("abort_ack_port", 64'(p_ack), 64'b100);
    p_req = 3'b000;
    repeat (2) @(negedge clk);
    d2 = done_cnt[2];
    resetn = 1'b0;
    init_hold = 1'b1;
    @(negedge clk);
    check_reset_values("abort");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(done_cnt[2] - d2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
